// File: rtl/osd_du_arbiter.sv
// Round-robin arbiter sharing one CPU debug-unit access port between requesters.
// One outstanding access at a time, with ack-timeout error reporting.
module osd_du_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          du_stb_i,
    output logic                          du_we_i,
    output logic [ADDR_WIDTH-1:0]         du_adr_i,
    output logic [DATA_WIDTH-1:0]         du_dat_i,
    input  logic                          du_ack_o,
    input  logic [DATA_WIDTH-1:0]         du_dat_o,
    output logic                          busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant;
    logic [GW-1:0] winner;
    logic [GW-1:0] idx;
    logic          found;
    logic [CW-1:0] cnt;
    logic          timeout_hit;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            // cnt is 0 in the first ACCESS cycle, so TIMEOUT-1 marks the last one.
            assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant      <= '0;
            cnt        <= '0;
            req_ack    <= '0;
            req_err    <= '0;
            req_rdata  <= '0;
            du_stb_i   <= 1'b0;
            du_we_i    <= 1'b0;
            du_adr_i   <= '0;
            du_dat_i   <= '0;
            busy       <= 1'b0;
        end else begin
            req_ack <= '0;
            req_err <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= ACCESS;
                        grant      <= winner;
                        last_grant <= winner;
                        cnt        <= '0;
                        du_stb_i   <= 1'b1;
                        du_we_i    <= req_we[winner];
                        du_adr_i   <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        du_dat_i   <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                        busy       <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (du_ack_o) begin
                        state          <= IDLE;
                        du_stb_i       <= 1'b0;
                        busy           <= 1'b0;
                        req_ack[grant] <= 1'b1;
                        if (!du_we_i) begin
                            req_rdata <= du_dat_o;
                        end
                    end else if (timeout_hit) begin
                        state          <= IDLE;
                        du_stb_i       <= 1'b0;
                        busy           <= 1'b0;
                        req_err[grant] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    du_stb_i <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
